// File: rtl/risc_dbg_pkg.sv
// Shared types and default parameters for the risc_debug_port halt/debug arbiter.
package risc_dbg_pkg;

  // Arbiter states: processor owns port B (StRun, StDrain) or debug owns it (StHalted, StRdWait).
  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2,
    StRdWait = 2'd3
  } dbg_state_e;

  localparam int unsigned DefDw    = 32;
  localparam int unsigned DefAw    = 12;
  localparam int unsigned DefRdLat = 1;

endpackage

// File: rtl/risc_dbg_rdlat.sv
// Read-latency down-counter: loaded on a debug read handshake, signals o_done in the cycle
// where memory read data is valid.
module risc_dbg_rdlat #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_active,
  output logic o_done
);

  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LoadVal = CW'(RD_LAT - 1);

  logic [CW-1:0] r_cnt;

  // Count down from RD_LAT-1 while a read is waiting; hold at zero otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LoadVal;
    end else if (i_active && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = i_active & (r_cnt == '0);

endmodule

// File: rtl/risc_debug_port.sv
// Halt/debug arbiter for memory port B. Passes processor traffic through while running, stalls
// the processor at a safe point on a halt request, then serves single-word debug reads/writes.
// Optional feature: define RISC_DBG_AUTOINC_EN to add i_dbg_inc and an auto-incrementing
// debug address pointer.
module risc_debug_port
  import risc_dbg_pkg::*;
#(
  parameter int unsigned DW     = DefDw,
  parameter int unsigned AW     = DefAw,
  parameter int unsigned RD_LAT = DefRdLat
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_hlt_req,
  output logic          o_hlt_ack,
  output logic          o_cpu_hlt,
  input  logic          i_cpu_idle,
  input  logic          i_cpu_web,
  input  logic [AW-1:0] i_cpu_addrb,
  input  logic [DW-1:0] i_cpu_dinb,
  output logic [DW-1:0] o_cpu_doutb,
  input  logic          i_dbg_valid,
`ifdef RISC_DBG_AUTOINC_EN
  input  logic          i_dbg_inc,
`endif
  output logic          o_dbg_ready,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic          o_dbg_rvalid,
  output logic [DW-1:0] o_dbg_rdata,
  output logic          o_mem_web,
  output logic [AW-1:0] o_mem_addrb,
  output logic [DW-1:0] o_mem_dinb,
  input  logic [DW-1:0] i_mem_doutb
);

  dbg_state_e    r_state;
  dbg_state_e    w_state_next;
  logic          w_hs;
  logic          w_rd_hs;
  logic          w_wr_hs;
  logic          w_rd_done;
  logic [AW-1:0] w_dbg_addr;
  logic [AW-1:0] r_rd_addr;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;

  // Debug is only ready in StHalted, so a handshake implies that state.
  assign w_hs    = (r_state == StHalted) & i_dbg_valid;
  assign w_rd_hs = w_hs & ~i_dbg_we;
  assign w_wr_hs = w_hs & i_dbg_we;

`ifdef RISC_DBG_AUTOINC_EN
  logic [AW-1:0] r_ptr;

  assign w_dbg_addr = i_dbg_inc ? r_ptr : i_dbg_addr;

  // Pointer always advances past the address just used, whichever source supplied it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= w_dbg_addr + AW'(1);
    end
  end
`else
  assign w_dbg_addr = i_dbg_addr;
`endif

  risc_dbg_rdlat #(
    .RD_LAT (RD_LAT)
  ) u_rdlat (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_rd_hs),
    .i_active (r_state == StRdWait),
    .o_done   (w_rd_done)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; an accepted access always wins over a dropped halt request.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun: begin
        if (i_hlt_req) w_state_next = StDrain;
      end
      StDrain: begin
        if (!i_hlt_req)     w_state_next = StRun;
        else if (i_cpu_idle) w_state_next = StHalted;
      end
      StHalted: begin
        if (w_rd_hs)         w_state_next = StRdWait;
        else if (w_wr_hs)    w_state_next = StHalted;
        else if (!i_hlt_req) w_state_next = StRun;
      end
      StRdWait: begin
        if (w_rd_done) w_state_next = StHalted;
      end
      default: w_state_next = StRun;
    endcase
  end

  // Read address capture and read-data return; reset mid-read discards the pending result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_addr <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rvalid <= w_rd_done;
      if (w_rd_hs)   r_rd_addr <= w_dbg_addr;
      if (w_rd_done) r_rdata   <= i_mem_doutb;
    end
  end

  // Output decode: port-B mux and handshake/status flags; everything low while in reset.
  always_comb begin
    o_hlt_ack    = 1'b0;
    o_cpu_hlt    = 1'b0;
    o_dbg_ready  = 1'b0;
    o_cpu_doutb  = '0;
    o_mem_web    = 1'b0;
    o_mem_addrb  = '0;
    o_mem_dinb   = '0;
    o_dbg_rvalid = r_rvalid;
    o_dbg_rdata  = r_rdata;
    if (!i_rst) begin
      unique case (r_state)
        StRun, StDrain: begin
          o_cpu_hlt   = (r_state == StDrain);
          o_mem_web   = i_cpu_web;
          o_mem_addrb = i_cpu_addrb;
          o_mem_dinb  = i_cpu_dinb;
          o_cpu_doutb = i_mem_doutb;
        end
        StHalted: begin
          o_cpu_hlt   = 1'b1;
          o_hlt_ack   = 1'b1;
          o_dbg_ready = 1'b1;
          o_mem_web   = w_wr_hs;
          o_mem_addrb = w_dbg_addr;
          o_mem_dinb  = i_dbg_wdata;
        end
        StRdWait: begin
          o_cpu_hlt   = 1'b1;
          o_hlt_ack   = 1'b1;
          o_mem_addrb = r_rd_addr;
          o_mem_dinb  = i_dbg_wdata;
        end
        default: ;
      endcase
    end
  end

endmodule
